// File: rtl/rtc_ctrl_pkg.sv
// Shared definitions for the real-time clock controller: state and load-select
// encodings, packed-BCD limits and digit helpers.
package rtc_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun  = 2'b00,
        StSetH = 2'b01,
        StSetM = 2'b10,
        StSetS = 2'b11
    } state_e;

    localparam logic [1:0] LdNone = 2'b00;
    localparam logic [1:0] LdHour = 2'b01;
    localparam logic [1:0] LdMin  = 2'b10;
    localparam logic [1:0] LdSec  = 2'b11;

    localparam logic [7:0] MaxSec    = 8'h59;
    localparam logic [7:0] MaxHour24 = 8'h23;
    localparam logic [7:0] MaxHour12 = 8'h11;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Plain BCD +1 without wrap; the caller handles the field limit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_ctrl_bcd_field.sv
// Packed-BCD wrap counter for one time field; wrap flags that the field sits at
// its limit so the parent can chain carries.
module bcd_field
    import rtc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       ld,
    input  logic [7:0] data,
    input  logic [7:0] max,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (ld) begin
            value_d = data;
        end else if (inc) begin
            value_d = (value_q == max) ? 8'h00 : bcd_inc(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign wrap  = (value_q == max);

endmodule

// File: rtl/rtc_ctrl.sv
// Real-time clock controller: hh:mm:ss in packed BCD with a set-mode state
// machine, validated direct loads and a day-carry pulse.
module rtc_ctrl
    import rtc_ctrl_pkg::*;
#(
    parameter int unsigned HOURS = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode,
    input  logic       inc,
    input  logic       ld,
    input  logic [1:0] ld_sel,
    input  logic [7:0] data,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [1:0] setting,
    output logic       day_c,
    output logic       err
);

    localparam logic [7:0] HourMax = (HOURS == 12) ? MaxHour12 : MaxHour24;

    state_e     state_q, state_d;
    logic       day_c_q, day_c_d;
    logic       err_q, err_d;

    logic       load_req, load_ok;
    logic [7:0] load_max;
    logic       tick_run, set_inc;
    logic       sec_inc, min_inc, hour_inc;
    logic       sec_wrap, min_wrap, hour_wrap;

    // Any real load request owns the cycle: mode, tick and inc are all dropped,
    // even if the load itself is rejected.
    always_comb begin
        load_req = ld && (ld_sel != LdNone);
        load_max = (ld_sel == LdHour) ? HourMax : MaxSec;
        load_ok  = load_req && bcd_valid(data) && (data <= load_max);
        err_d    = load_req && !load_ok;

        tick_run = !load_req && tick && (state_q == StRun);
        set_inc  = !load_req && !mode && inc;

        sec_inc  = tick_run || (set_inc && state_q == StSetS);
        min_inc  = (tick_run && sec_wrap) || (set_inc && state_q == StSetM);
        hour_inc = (tick_run && sec_wrap && min_wrap) || (set_inc && state_q == StSetH);
        day_c_d  = tick_run && sec_wrap && min_wrap && hour_wrap;
    end

    always_comb begin
        state_d = state_q;
        if (!load_req && mode) begin
            unique case (state_q)
                StRun:   state_d = StSetH;
                StSetH:  state_d = StSetM;
                StSetM:  state_d = StSetS;
                StSetS:  state_d = StRun;
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            day_c_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            day_c_q <= day_c_d;
            err_q   <= err_d;
        end
    end

    bcd_field u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .ld    (load_ok && ld_sel == LdSec),
        .data  (data),
        .max   (MaxSec),
        .value (sec),
        .wrap  (sec_wrap)
    );

    bcd_field u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .ld    (load_ok && ld_sel == LdMin),
        .data  (data),
        .max   (MaxSec),
        .value (min),
        .wrap  (min_wrap)
    );

    bcd_field u_hour (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hour_inc),
        .ld    (load_ok && ld_sel == LdHour),
        .data  (data),
        .max   (HourMax),
        .value (hour),
        .wrap  (hour_wrap)
    );

    assign setting = state_q;
    assign day_c   = day_c_q;
    assign err     = err_q;

endmodule

// File: tb/tb_rtc_ctrl.sv
// Bench for rtc_ctrl: directed vector table, hand sequences and random stimulus
// checked against an integer-seconds reference model for both hour moduli.
module tb_rtc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick, mode, inc, ld;
    logic [1:0] ld_sel;
    logic [7:0] data;

    logic [7:0] hour24, min24, sec24, hour12, min12, sec12;
    logic [1:0] set24, set12;
    logic       dc24, dc12, err24, err12;

    int errors = 0;
    int checks = 0;

    rtc_ctrl #(.HOURS(24)) dut24 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .inc(inc), .ld(ld),
        .ld_sel(ld_sel), .data(data), .hour(hour24), .min(min24), .sec(sec24),
        .setting(set24), .day_c(dc24), .err(err24)
    );

    rtc_ctrl #(.HOURS(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .inc(inc), .ld(ld),
        .ld_sel(ld_sel), .data(data), .hour(hour12), .min(min12), .sec(sec12),
        .setting(set12), .day_c(dc12), .err(err12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h, m, s, st;
        bit day, er;
    } mstate_t;

    mstate_t m24, m12;

    typedef struct {
        logic       rst_n, tick, mode, inc, ld;
        logic [1:0] sel;
        logic [7:0] data;
        logic [7:0] h, m, s;
        logic [1:0] st;
        logic       dc, er;
    } vec_t;

    vec_t vq[$];

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    // Model keeps time as whole numbers and applies the rules directly.
    function automatic mstate_t mstep(input mstate_t m, input int hours, input bit r,
                                      input bit tk, input bit md, input bit ic,
                                      input bit l, input logic [1:0] sel,
                                      input logic [7:0] d);
        mstate_t n = m;
        int hi, lo, v, lim, t;
        n.day = 0;
        n.er  = 0;
        if (!r) begin
            n.h = 0; n.m = 0; n.s = 0; n.st = 0;
            return n;
        end
        if (l && sel != 2'b00) begin
            hi = int'(d[7:4]);
            lo = int'(d[3:0]);
            v = hi * 10 + lo;
            lim = (sel == 2'b01) ? hours - 1 : 59;
            if (hi <= 9 && lo <= 9 && v <= lim) begin
                if (sel == 2'b01) n.h = v;
                else if (sel == 2'b10) n.m = v;
                else n.s = v;
            end else begin
                n.er = 1;
            end
            return n;
        end
        if (m.st == 0 && tk) begin
            t = m.h * 3600 + m.m * 60 + m.s + 1;
            if (t == hours * 3600) begin
                t = 0;
                n.day = 1;
            end
            n.h = t / 3600;
            n.m = (t / 60) % 60;
            n.s = t % 60;
        end
        if (m.st != 0 && ic && !md) begin
            if (m.st == 1) n.h = (m.h + 1) % hours;
            if (m.st == 2) n.m = (m.m + 1) % 60;
            if (m.st == 3) n.s = (m.s + 1) % 60;
        end
        if (md) n.st = (m.st + 1) % 4;
        return n;
    endfunction

    task automatic check_model(input string name, input mstate_t m, input logic [7:0] h,
                               input logic [7:0] mi, input logic [7:0] s,
                               input logic [1:0] st, input logic dc, input logic er);
        logic [27:0] got, want;
        got  = {h, mi, s, st, dc, er};
        want = {to_bcd(m.h), to_bcd(m.m), to_bcd(m.s), 2'(m.st), m.day, m.er};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got h=%h m=%h s=%h set=%b day_c=%b err=%b, want h=%h m=%h s=%h set=%b day_c=%b err=%b",
                     name, h, mi, s, st, dc, er, want[27:20], want[19:12], want[11:4],
                     want[3:2], want[1], want[0]);
        end
    endtask

    task automatic check_const(input string name, input logic [27:0] got,
                               input logic [27:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got h:m:s=%h:%h:%h set=%b day_c=%b err=%b, want %h:%h:%h set=%b day_c=%b err=%b",
                     name, got[27:20], got[19:12], got[11:4], got[3:2], got[1], got[0],
                     want[27:20], want[19:12], want[11:4], want[3:2], want[1], want[0]);
        end
    endtask

    task automatic step(input logic r, input logic tk, input logic md, input logic ic,
                        input logic l, input logic [1:0] sel, input logic [7:0] d,
                        input string name);
        rst_n = r; tick = tk; mode = md; inc = ic; ld = l; ld_sel = sel; data = d;
        m24 = mstep(m24, 24, r, tk, md, ic, l, sel, d);
        m12 = mstep(m12, 12, r, tk, md, ic, l, sel, d);
        @(posedge clk);
        #1;
        check_model({name, "/h24"}, m24, hour24, min24, sec24, set24, dc24, err24);
        check_model({name, "/h12"}, m12, hour12, min12, sec12, set12, dc12, err12);
    endtask

    task automatic add(input logic r, input logic tk, input logic md, input logic ic,
                       input logic l, input logic [1:0] sel, input logic [7:0] d,
                       input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s,
                       input logic [1:0] st, input logic dc, input logic er);
        vec_t v;
        v.rst_n = r; v.tick = tk; v.mode = md; v.inc = ic; v.ld = l; v.sel = sel;
        v.data = d; v.h = h; v.m = mi; v.s = s; v.st = st; v.dc = dc; v.er = er;
        vq.push_back(v);
    endtask

    initial begin
        m24 = '{0, 0, 0, 0, 0, 0};
        m12 = '{0, 0, 0, 0, 0, 0};
        rst_n = 1'b0; tick = 1'b0; mode = 1'b0; inc = 1'b0; ld = 1'b0;
        ld_sel = 2'b00; data = 8'h00;

        // rst tick mode inc ld sel data | hour min sec set day_c err (HOURS=24)
        add(0, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0);
        add(1, 0, 0, 0, 1, 2'd3, 8'h58, 8'h00, 8'h00, 8'h58, 2'd0, 0, 0);
        add(1, 0, 0, 0, 1, 2'd2, 8'h59, 8'h00, 8'h59, 8'h58, 2'd0, 0, 0);
        add(1, 0, 0, 0, 1, 2'd1, 8'h23, 8'h23, 8'h59, 8'h58, 2'd0, 0, 0);
        add(1, 1, 0, 0, 0, 2'd0, 8'h00, 8'h23, 8'h59, 8'h59, 2'd0, 0, 0);
        add(1, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0);
        add(1, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0);
        add(1, 0, 0, 0, 1, 2'd2, 8'h60, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1);
        add(1, 0, 0, 0, 1, 2'd3, 8'h2A, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1);
        add(1, 0, 0, 0, 1, 2'd0, 8'h12, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0);
        add(1, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0);
        add(1, 0, 0, 0, 1, 2'd3, 8'h09, 8'h00, 8'h00, 8'h09, 2'd0, 0, 0);
        add(1, 1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h10, 2'd1, 0, 0);
        add(1, 0, 1, 1, 1, 2'd2, 8'h45, 8'h00, 8'h45, 8'h10, 2'd1, 0, 0);
        add(1, 0, 1, 0, 0, 2'd0, 8'h00, 8'h00, 8'h45, 8'h10, 2'd2, 0, 0);
        add(1, 0, 0, 0, 1, 2'd1, 8'h12, 8'h12, 8'h45, 8'h10, 2'd2, 0, 0);
        add(1, 0, 0, 0, 1, 2'd2, 8'h34, 8'h12, 8'h34, 8'h10, 2'd2, 0, 0);
        add(1, 0, 0, 0, 1, 2'd3, 8'h56, 8'h12, 8'h34, 8'h56, 2'd2, 0, 0);
        add(1, 0, 0, 1, 0, 2'd0, 8'h00, 8'h12, 8'h35, 8'h56, 2'd2, 0, 0);
        add(0, 1, 1, 1, 1, 2'd1, 8'h05, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0);
        add(1, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h01, 2'd0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst_n, vq[i].tick, vq[i].mode, vq[i].inc, vq[i].ld, vq[i].sel,
                 vq[i].data, $sformatf("vec%0d", i));
            check_const($sformatf("vec%0d/const", i), {hour24, min24, sec24, set24, dc24, err24},
                        {vq[i].h, vq[i].m, vq[i].s, vq[i].st, vq[i].dc, vq[i].er});
        end

        // 12-hour rollover from 11:59:59.
        step(0, 0, 0, 0, 0, 2'd0, 8'h00, "h12_rst");
        step(1, 0, 0, 0, 1, 2'd1, 8'h11, "h12_ldh");
        step(1, 0, 0, 0, 1, 2'd2, 8'h59, "h12_ldm");
        step(1, 0, 0, 0, 1, 2'd3, 8'h59, "h12_lds");
        step(1, 1, 0, 0, 0, 2'd0, 8'h00, "h12_tick");
        check_const("h12_roll", {hour12, min12, sec12, set12, dc12, err12},
                    {8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0});
        check_const("h24_noroll", {hour24, min24, sec24, set24, dc24, err24},
                    {8'h12, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0});
        step(1, 0, 0, 0, 0, 2'd0, 8'h00, "h12_idle");
        check_const("h12_dc_drop", {hour12, min12, sec12, set12, dc12, err12},
                    {8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0});

        // Set-hour mode: ticks frozen, 15 increments wrap the hour.
        step(1, 0, 0, 0, 1, 2'd1, 8'h10, "set_ldh");
        step(1, 0, 0, 0, 1, 2'd2, 8'h20, "set_ldm");
        step(1, 0, 0, 0, 1, 2'd3, 8'h30, "set_lds");
        step(1, 0, 1, 0, 0, 2'd0, 8'h00, "set_mode");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 2'd0, 8'h00, "set_tick");
        check_const("set_frozen", {hour24, min24, sec24, set24, dc24, err24},
                    {8'h10, 8'h20, 8'h30, 2'd1, 1'b0, 1'b0});
        for (int i = 0; i < 15; i++) step(1, i[0], 0, 1, 0, 2'd0, 8'h00, "set_inc");
        check_const("set_inc24", {hour24, min24, sec24, set24, dc24, err24},
                    {8'h01, 8'h20, 8'h30, 2'd1, 1'b0, 1'b0});
        check_const("set_inc12", {hour12, min12, sec12, set12, dc12, err12},
                    {8'h01, 8'h20, 8'h30, 2'd1, 1'b0, 1'b0});

        // Random phase against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic       r, tk, md, ic, l;
            logic [1:0] sel;
            logic [7:0] d;
            r   = ($urandom_range(99, 0) != 0);
            tk  = ($urandom_range(1, 0) == 1);
            md  = ($urandom_range(19, 0) == 0);
            ic  = ($urandom_range(2, 0) == 0);
            l   = ($urandom_range(9, 0) == 0);
            sel = 2'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) d = {4'($urandom_range(5, 0)), 4'($urandom_range(9, 0))};
            else d = 8'($urandom);
            step(r, tk, md, ic, l, sel, d, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
